// File: rtl/alu_op_sequencer.sv
// Mini ALU sequencer: drives one 6-bit adder through single-cycle ADD/SUB and a
// 6-iteration unsigned shift-and-add multiply, with registered result and flags.

module ripple_carry_adder #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   total;

    // SUB is x + ~y + 1; c_out is reported as borrow, so the raw carry is inverted.
    always_comb begin
        y_eff    = y ^ {WIDTH{sel}};
        total    = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sel};
        sum      = total[WIDTH-1:0];
        c_out    = total[WIDTH] ^ sel;
        overflow = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end
endmodule

module alu_op_sequencer #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               overflow,
    output logic               err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADDSUB = 2'd1;
    localparam logic [1:0] MUL    = 2'd2;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [2:0] LAST_ITER = 3'(WIDTH - 1);

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2:0]         cnt;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_sel;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               add_ovf;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        add_x   = (state == MUL) ? hi  : a_q;
        add_y   = (state == MUL) ? a_q : b_q;
        add_sel = (state == ADDSUB) && (op_q == OP_SUB);
    end

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .x        (add_x),
        .y        (add_y),
        .sel      (add_sel),
        .sum      (add_sum),
        .c_out    (add_cout),
        .overflow (add_ovf)
    );

    // One shift-and-add step: conditionally add the multiplicand into hi, then shift right.
    always_comb begin
        if (lo[0]) begin
            mul_next = {add_cout, add_sum, lo[WIDTH-1:1]};
        end else begin
            mul_next = {1'b0, hi, lo[WIDTH-1:1]};
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                        if (op == OP_MUL) begin
                            hi    <= '0;
                            lo    <= b;
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            state <= ADDSUB;
                        end
                    end
                end
                ADDSUB: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (op_q == OP_ILL) begin
                        result   <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        result   <= {{WIDTH{1'b0}}, add_sum};
                        carry    <= add_cout;
                        overflow <= add_ovf;
                        err      <= 1'b0;
                    end
                end
                MUL: begin
                    {hi, lo} <= mul_next;
                    cnt      <= cnt + 3'd1;
                    if (cnt == LAST_ITER) begin
                        result   <= mul_next;
                        done     <= 1'b1;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that owns one instance of the team's 6-bit ripple_carry_adder and sequences it through single-cycle ADD/SUB and a 6-iteration unsigned shift-and-add MUL.
- Sits between the Mini ALU command source (start/op/operands) and the adder.
- Registers results and flags, and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 6, operand width; fixed to the adder width, and only 6 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only when busy=0.
- op  input  2  00 ADD, 01 SUB, 10 MUL, 11 illegal.
- a  input  WIDTH  operand A (adder x; multiplicand).
- b  input  WIDTH  operand B (adder y; multiplier).
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  2*WIDTH  ADD/SUB: {6'b0, sum}; MUL: unsigned 12-bit product.
- carry  output  1  adder c_out (carry for ADD, borrow for SUB); 0 for MUL and illegal op.
- overflow  output  1  adder signed overflow for ADD/SUB; 0 for MUL and illegal op.
- err  output  1  high together with done for an illegal op.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy, done, err, carry, overflow = 0; result = 0.
  - Internal operand, accumulator and counter registers = 0.
  - First start is accepted on the first clock edge after reset deasserts.
- States: IDLE, ADDSUB, MUL.
- Command acceptance:
  - In IDLE with start=1 at edge k: latch a, b, op.
  - ADD/SUB/illegal -> ADDSUB. MUL -> MUL with hi=0, lo=b, cnt=0.
  - busy=1 from after edge k.
  - start with busy=1 is ignored; latched operands do not change.
- Adder drive:
  - x=latched a (ADDSUB) or hi (MUL).
  - y=latched b (ADDSUB) or latched a (MUL).
  - sel=1 only for SUB; otherwise 0.
- ADDSUB, edge k+1:
  - result={6'b0,sum}, carry=c_out, overflow=overflow, err=0.
  - For op 11: result=0, flags=0, err=1; the adder output is discarded.
  - done=1, busy=0, state -> IDLE.
  - Latency: 1 edge after the accepting edge.
- MUL, one iteration per edge k+1..k+6:
  - If lo[0]=1: {hi,lo} <= {c_out, sum, lo[5:1]} (adder sum = hi + a).
  - Else: {hi,lo} <= {1'b0, hi, lo[5:1]}.
  - cnt increments each edge. The iteration with cnt=5 (edge k+6) writes result={hi,lo} of the new value, done=1, carry=0, overflow=0, err=0, state -> IDLE.
  - Latency: 6 edges after the accepting edge.
  - Product never overflows 12 bits, so no overflow detection.
- done is a registered pulse lasting exactly one cycle. During that cycle state=IDLE and busy=0, so a start in the done cycle is accepted (back-to-back, no bubble).
- result, carry, overflow and err hold their values until the next completion or reset. They are not cleared on start.
- cnt runs 0..5 and never wraps in operation; cnt=5 always terminates.
- SUB arithmetic is two's complement (x + ~y + 1). carry=1 means borrow (a<b unsigned).

Test Plan:
- Reset, then ADD a=5, b=9 at edge k -> at edge k+1: done=1 for one cycle, result=0x00E, carry=0, overflow=0, busy back to 0.
- ADD a=0x1F, b=0x01 -> result=0x020, overflow=1, carry=0. Then SUB a=3, b=5 -> result=0x03E, carry=1, overflow=0. SUB a=0x20, b=0x01 -> result=0x01F, overflow=1.
- MUL a=63, b=63 -> busy high 6 cycles, done at edge k+6, result=0xF81, carry=0, overflow=0. MUL a=0, b=37 -> result=0x000. MUL a=12, b=1 -> result=0x00C.
- op=11, a=7, b=7 -> done at edge k+1 with err=1, result=0, carry=0, overflow=0. A following ADD 1+1 -> err=0, result=0x002.
- During MUL 63*63, pulse start with ADD 1+1 at edge k+2 -> ignored; done only at k+6 with result=0xF81. Issue a start in the done cycle (ADD 2+3) -> accepted, result=0x005 one edge later.
- Assert reset asynchronously mid-MUL (between edges k+3 and k+4) -> busy, done, result and flags go to 0 immediately with no clock. Release reset, then MUL a=3, b=4 -> result=0x00C at 6 edges.
